// File: rtl/mdu_mul.sv
// rtl/mdu_mul.sv - radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
// Signed operands are reduced to magnitudes on accept; the sign is reapplied to the full product.
module mdu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  input  logic [1:0]       i_mul_op,
  input  logic             i_mul_valid,
  output logic             o_mul_busy,
  output logic             o_mul_ready,
  output logic [WIDTH-1:0] o_mul_rd
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     rd_q, rd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic                 rs1_neg;
  logic                 rs2_neg;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_final;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;

    rs1_neg = ((i_mul_op == OP_MULH) || (i_mul_op == OP_MULHSU)) && i_multiplicand[WIDTH-1];
    rs2_neg = (i_mul_op == OP_MULH) && i_multiplier[WIDTH-1];

    // Add into the upper half, then shift the whole accumulator right one bit.
    step_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step   = {step_sum, acc_q[WIDTH-1:1]};
    prod_final = neg_q ? (~acc_step + 1'b1) : acc_step;

    case (state_q)
      S_IDLE: begin
        if (i_mul_valid) begin
          mcand_d  = rs1_neg ? (~i_multiplicand + 1'b1) : i_multiplicand;
          mplier_d = rs2_neg ? (~i_multiplier + 1'b1) : i_multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = rs1_neg ^ rs2_neg;
          op_d     = i_mul_op;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          rd_d    = (op_q == OP_MUL) ? prod_final[WIDTH-1:0] : prod_final[2*WIDTH-1:WIDTH];
          ready_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      rd_q     <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign o_mul_busy  = busy_q;
  assign o_mul_ready = ready_q;
  assign o_mul_rd    = rd_q;

endmodule

// File: tb/tb_mdu_mul.sv
// tb/tb_mdu_mul.sv - directed self-checking bench for mdu_mul
// Latency n means o_mul_ready is sampled high by the rising edge n edges after the accept edge.
module tb_mdu_mul;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [1:0]  mul_op;
  logic        valid;
  logic        busy;
  logic        ready;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  bb_op  [3] = '{OP_MULHU, OP_MUL, OP_MULH};
  logic [31:0] bb_a   [3] = '{32'h0001_0000, 32'h1234_5678, 32'h8000_0000};
  logic [31:0] bb_b   [3] = '{32'h0001_0000, 32'h0000_0010, 32'h7FFF_FFFF};
  logic [31:0] bb_exp [3] = '{32'h0000_0001, 32'h2345_6780, 32'hC000_0000};

  mdu_mul #(.WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .i_mul_op       (mul_op),
    .i_mul_valid    (valid),
    .o_mul_busy     (busy),
    .o_mul_ready    (ready),
    .o_mul_rd       (rd)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int pulses,
                        output logic busy1);
    @(negedge clk);
    mul_op = op; mcand = a; mplier = b; valid = 1'b1;
    lat = 0; pulses = 0; res = 32'h0; busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        valid = 1'b0;
        busy1 = busy;
      end
      if (ready) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          res = rd;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; mul_op = OP_MUL; mcand = 32'd3; mplier = 32'd5;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; int p; logic b1;
    run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, r, lat, p, b1);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_rd got=%h exp=ffffffeb", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (p !== 1) begin failures++; $display("FAIL mul_pulses got=%0d exp=1", p); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL mul_busy got=%b exp=1", b1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_after got=%b exp=0", busy); end
    checks++; if (rd !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_rd_hold got=%h exp=ffffffeb", rd); end
    run_op(OP_MUL, 32'h1234_5678, 32'h0000_0010, r, lat, p, b1);
    checks++; if (r !== 32'h2345_6780) begin failures++; $display("FAIL mul_rd2 got=%h exp=23456780", r); end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat; int p; logic b1;
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, r, lat, p, b1);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL mulh_minneg got=%h exp=40000000", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL mulh_latency got=%0d exp=33", lat); end
    run_op(OP_MULH, 32'h0000_0000, 32'hFFFF_FFFB, r, lat, p, b1);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL mulh_zero got=%h exp=00000000", r); end
    run_op(OP_MULH, 32'hFFFF_FFF9, 32'h0000_0003, r, lat, p, b1);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_neg got=%h exp=ffffffff", r); end
    run_op(OP_MULH, 32'h8000_0000, 32'h7FFF_FFFF, r, lat, p, b1);
    checks++; if (r !== 32'hC000_0000) begin failures++; $display("FAIL mulh_mixed got=%h exp=c0000000", r); end
  endtask

  task automatic test_mulhsu_mulhu();
    logic [31:0] r; int lat; int p; logic b1;
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, p, b1);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, p, b1);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
    run_op(OP_MULHSU, 32'h0000_0003, 32'hFFFF_FFFE, r, lat, p, b1);
    checks++; if (r !== 32'h0000_0002) begin failures++; $display("FAIL mulhsu_pos got=%h exp=00000002", r); end
  endtask

  task automatic test_ignore_valid();
    int lat = 0; int p = 0; logic [31:0] r = 32'h0;
    @(negedge clk);
    mul_op = OP_MUL; mcand = 32'h0000_0007; mplier = 32'hFFFF_FFFD; valid = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) valid = 1'b0;
      if (n == 5) begin
        mul_op = OP_MULHU; mcand = 32'h1234_5678; mplier = 32'h0000_0010; valid = 1'b1;
      end
      if (n == 6) valid = 1'b0;
      if (ready) begin
        p++;
        if (lat == 0) begin lat = n; r = rd; end
      end
    end
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL ignore_rd got=%h exp=ffffffeb", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if (p !== 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", p); end
  endtask

  task automatic test_reset_abort();
    int p = 0; logic [31:0] r; int lat; int pr; logic b1;
    @(negedge clk);
    mul_op = OP_MULH; mcand = 32'h0000_0005; mplier = 32'h0000_0006; valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) valid = 1'b0;
      if (ready) p++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL abort_rd got=%h exp=00000000", rd); end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready) p++;
    end
    checks++; if (p !== 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", p); end
    run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, r, lat, pr, b1);
    checks++; if (r !== 32'h0000_0001) begin failures++; $display("FAIL abort_next got=%h exp=00000001", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL abort_next_lat got=%0d exp=33", lat); end
  endtask

  task automatic test_back_to_back();
    int k = 0; int last = 0;
    @(negedge clk);
    mul_op = bb_op[0]; mcand = bb_a[0]; mplier = bb_b[0]; valid = 1'b1;
    for (int n = 1; n <= 200 && k < 3; n++) begin
      @(negedge clk);
      if (ready) begin
        checks++;
        if (rd !== bb_exp[k]) begin
          failures++; $display("FAIL b2b_rd%0d got=%h exp=%h", k, rd, bb_exp[k]);
        end
        checks++;
        if (k == 0) begin
          if (n !== 33) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=33", n); end
        end else begin
          if (n - last !== 34) begin failures++; $display("FAIL b2b_interval%0d got=%0d exp=34", k, n - last); end
        end
        last = n;
        k++;
        if (k < 3) begin
          mul_op = bb_op[k]; mcand = bb_a[k]; mplier = bb_b[k];
        end else begin
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    checks++; if (k !== 3) begin failures++; $display("FAIL b2b_timeout got=%0d exp=3", k); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mul_op = 2'b00; mcand = 32'h0; mplier = 32'h0;
    test_reset();
    test_mul();
    test_mulh();
    test_mulhsu_mulhu();
    test_ignore_valid();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
